spi_alu_slave: RTL
==================

// Module: spi_alu_slave
// PURPOSE
//  Parametrised SPI-slave arithmetic unit, successor to the single-op SPI multiplier.
//  Receives an opcode and two WIDTH-bit operands MSB-first and executes one of several ALU/multiply ops.
//  Shifts a WIDTH-bit result back on MISO in the same nss-low frame.
//  Sits on the shared spi_if bus next to the other SPI peripherals; sclk/nss/mosi are oversampled by clock.
// PARAMETERS
//  WIDTH     32  operand and result width in bits (>=8)
//  OPW       4   opcode width in bits (fixed encoding below uses 4)
//  SYNC_FFS  2   synchroniser depth on sclk, nss and mosi (>=2)
// PORTS
//  clock     in   1       system clock; single clock domain
//  reset     in   1       synchronous, active-high reset
//  spi_if    SLAVE modport: nss/sclk/mosi in, miso out (1 bit each)
//  busy      out  1       high from first opcode bit until return to IDLE
//  done      out  1       one-clock pulse when the last result bit has been shifted out
//  err       out  1       sticky: unknown opcode in last frame; cleared at next frame start
// BEHAVIOUR
//  - Inputs pass SYNC_FFS flops; sclk rise/fall detected from last two synced samples.
//  - Master keeps sclk high and low >= SYNC_FFS+2 clocks each; SPI mode 0 (sample rise, shift fall).
//  - FSM: IDLE -> RX_OP -> RX_A -> RX_B -> EXEC -> TX -> WAIT_NSS -> IDLE.
//    IDLE: synced nss low -> RX_OP, bit counter=0, shift reg=0, err=0.
//    RX_OP/RX_A/RX_B: shift mosi in on each sclk rise; after OPW/WIDTH/WIDTH rises latch and advance.
//    EXEC: one clock; result loaded into TX shift reg; miso = result[WIDTH-1] from next clock.
//    TX: on each sclk fall shift left (fill 0); after WIDTH falls pulse done, go WAIT_NSS.
//    WAIT_NSS: miso=0; stay until nss high, then IDLE (no retrigger without nss toggle).
//  - nss high in any state other than IDLE: abort to IDLE next clock; no done; operands kept.
//  - sclk edges while nss high are ignored; sclk rise and nss rise same clock: abort wins.
//  - Opcodes: 0000 ADD, 0001 SUB (A-B), 0010 AND, 0011 OR, 0100 XOR,
//    0101 SHL A<<B[log2(WIDTH)-1:0], 0110 SHR logical, 1001 MUL low WIDTH bits, 1010 MULHU high WIDTH bits.
//  - All arithmetic modulo 2^WIDTH, unsigned; multiply computed at 2*WIDTH.
//  - Unknown opcode: result 0, err=1 at EXEC, frame completes normally.
//  - miso = 0 outside TX. Reset values: miso=0, busy=0, done=0, err=0, state IDLE,
//    operands/opcode/counters/shift reg = 0. Reset mid-frame: same, no done.
//  - Latency: first result bit valid 1 clock after last B rise detected (EXEC).
// CONFIGURATION
//  SPI_ALU_SIGNED_EN defined: adds 1011 MULHS (signed high half) and 0111 SRA (arithmetic right shift).
//  Not defined: 1011 and 0111 are unknown opcodes (result 0, err=1); signed multiplier not built.
// TESTING (WIDTH=32)
//  - MUL 1001, A=7, B=6 -> MISO 0x0000002A, done pulse once, err=0.
//  - MULHU 1010, A=B=0xFFFFFFFF -> 0xFFFFFFFE; SUB A=5, B=7 -> 0xFFFFFFFE.
//  - nss high after 10 bits of A -> no done, IDLE; next frame ADD 1+2 -> 0x00000003.
//  - Opcode 1111, any A/B -> MISO all zeros, err=1; following valid frame clears err.
//  - Reset asserted during TX -> miso=0, busy=0 next clock; new frame SHL A=1, B=31 -> 0x80000000.
//  - SPI_ALU_SIGNED_EN: MULHS A=-2, B=3 -> 0xFFFFFFFF; SRA A=0x80000000, B=4 -> 0xF8000000.

Source files
------------

// File: rtl/spi_alu_slave_if.sv
// SPI bus bundle shared by the SPI peripherals on this port; the slave drives only miso.
interface spi_alu_slave_if;
  logic nss;
  logic sclk;
  logic mosi;
  logic miso;

  modport slave  (input nss, input sclk, input mosi, output miso);
  modport master (output nss, output sclk, output mosi, input miso);
endinterface

// File: rtl/spi_alu_slave.sv
// SPI mode-0 slave ALU: receives opcode, A and B MSB-first, then returns a WIDTH-bit result.
// Define SPI_ALU_SIGNED_EN to add MULHS (1011) and SRA (0111).
module spi_alu_slave #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned OPW      = 4,
  parameter int unsigned SYNC_FFS = 2
) (
  input  logic           clock,
  input  logic           reset,
  spi_alu_slave_if.slave spi_if,
  output logic           busy,
  output logic           done,
  output logic           err
);
  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned SW = $clog2(WIDTH);

  localparam logic [OPW-1:0] OpAdd   = OPW'(4'h0);
  localparam logic [OPW-1:0] OpSub   = OPW'(4'h1);
  localparam logic [OPW-1:0] OpAnd   = OPW'(4'h2);
  localparam logic [OPW-1:0] OpOr    = OPW'(4'h3);
  localparam logic [OPW-1:0] OpXor   = OPW'(4'h4);
  localparam logic [OPW-1:0] OpShl   = OPW'(4'h5);
  localparam logic [OPW-1:0] OpShr   = OPW'(4'h6);
  localparam logic [OPW-1:0] OpMul   = OPW'(4'h9);
  localparam logic [OPW-1:0] OpMulhu = OPW'(4'hA);
`ifdef SPI_ALU_SIGNED_EN
  localparam logic [OPW-1:0] OpSra   = OPW'(4'h7);
  localparam logic [OPW-1:0] OpMulhs = OPW'(4'hB);
`endif

  typedef enum logic [2:0] {
    StIdle, StRxOp, StRxA, StRxB, StExec, StTx, StWaitNss
  } state_e;

  state_e              state_q, state_d;
  logic [SYNC_FFS-1:0] nss_sync_q, nss_sync_d;
  logic [SYNC_FFS-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_FFS-1:0] mosi_sync_q, mosi_sync_d;
  logic                sclk_last_q;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]    shift_q, shift_d;
  logic [OPW-1:0]      op_q, op_d;
  logic [WIDTH-1:0]    a_q, a_d, b_q, b_d, tx_q, tx_d;
  logic                done_q, done_d, err_q, err_d;

  logic nss_s, sclk_s, mosi_s, sclk_rise, sclk_fall;

  assign nss_sync_d  = {nss_sync_q[SYNC_FFS-2:0], spi_if.nss};
  assign sclk_sync_d = {sclk_sync_q[SYNC_FFS-2:0], spi_if.sclk};
  assign mosi_sync_d = {mosi_sync_q[SYNC_FFS-2:0], spi_if.mosi};
  assign nss_s       = nss_sync_q[SYNC_FFS-1];
  assign sclk_s      = sclk_sync_q[SYNC_FFS-1];
  assign mosi_s      = mosi_sync_q[SYNC_FFS-1];
  assign sclk_rise   = sclk_s & ~sclk_last_q;
  assign sclk_fall   = ~sclk_s & sclk_last_q;

  logic [2*WIDTH-1:0] prod_u;
  logic [SW-1:0]      sh;
  logic [WIDTH-1:0]   result;
  logic               result_bad;

  assign sh     = b_q[SW-1:0];
  assign prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
`ifdef SPI_ALU_SIGNED_EN
  // Low 2*WIDTH bits of the sign-extended product equal the signed product.
  logic [2*WIDTH-1:0] prod_s;
  assign prod_s = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
`endif

  always_comb begin
    result     = '0;
    result_bad = 1'b0;
    case (op_q)
      OpAdd:   result = a_q + b_q;
      OpSub:   result = a_q - b_q;
      OpAnd:   result = a_q & b_q;
      OpOr:    result = a_q | b_q;
      OpXor:   result = a_q ^ b_q;
      OpShl:   result = a_q << sh;
      OpShr:   result = a_q >> sh;
      OpMul:   result = prod_u[WIDTH-1:0];
      OpMulhu: result = prod_u[2*WIDTH-1:WIDTH];
`ifdef SPI_ALU_SIGNED_EN
      OpSra:   result = $signed(a_q) >>> sh;
      OpMulhs: result = prod_s[2*WIDTH-1:WIDTH];
`endif
      default: result_bad = 1'b1;
    endcase
  end

  logic [WIDTH-1:0] shift_in;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    tx_d     = tx_q;
    done_d   = 1'b0;
    err_d    = err_q;
    shift_in = {shift_q[WIDTH-2:0], mosi_s};
    if (state_q != StIdle && nss_s) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!nss_s) begin
            state_d = StRxOp;
            cnt_d   = '0;
            shift_d = '0;
            err_d   = 1'b0;
          end
        end
        StRxOp, StRxA, StRxB: begin
          if (sclk_rise) begin
            shift_d = shift_in;
            cnt_d   = cnt_q + 1'b1;
            if (state_q == StRxOp && cnt_q == CW'(OPW - 1)) begin
              op_d    = shift_in[OPW-1:0];
              state_d = StRxA;
            end else if (state_q == StRxA && cnt_q == CW'(WIDTH - 1)) begin
              a_d     = shift_in;
              state_d = StRxB;
            end else if (state_q == StRxB && cnt_q == CW'(WIDTH - 1)) begin
              b_d     = shift_in;
              state_d = StExec;
            end
            if (state_d != state_q) begin
              shift_d = '0;
              cnt_d   = '0;
            end
          end
        end
        StExec: begin
          tx_d    = result;
          err_d   = result_bad;
          cnt_d   = '0;
          state_d = StTx;
        end
        StTx: begin
          // The first fall is the trailing edge of the last B bit; MSB must survive it.
          if (sclk_fall) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q != '0) tx_d = {tx_q[WIDTH-2:0], 1'b0};
            if (cnt_q == CW'(WIDTH)) begin
              done_d  = 1'b1;
              state_d = StWaitNss;
            end
          end
        end
        StWaitNss: state_d = StWaitNss;
        default:   state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      nss_sync_q  <= '1;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      sclk_last_q <= 1'b0;
      cnt_q       <= '0;
      shift_q     <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      tx_q        <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      nss_sync_q  <= nss_sync_d;
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_last_q <= sclk_s;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      tx_q        <= tx_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign spi_if.miso = (state_q == StTx) ? tx_q[WIDTH-1] : 1'b0;
  assign busy        = (state_q != StIdle);
  assign done        = done_q;
  assign err         = err_q;

endmodule
